gpio_pulse_checker: RTL and testbench
=====================================

# gpio_pulse_checker

Parametrised, synthesizable successor to the single-pin management-GPIO blink check used in bring-up. It watches `NUM_CH` asynchronous GPIO lines (e.g. `gpio`, selected `mprj_io` bits) on the FPGA build of Caravel, glitch-filters each one, and counts complete blinks. It reports per-channel pass/fail against a target count and a cycle timeout. It sits beside the SoC top as an on-board self-test monitor, replacing simulation-only `wait()`-chain monitors with hardware that also works on silicon/FPGA.

## Interface
- `NUM_CH`, default 1: number of monitored lines.
- `CNT_W`, default 8: blink counter / target width.
- `TMO_W`, default 24: timeout counter width.
- `SYNC_STAGES`, default 2: input synchroniser depth (≥2).
- `FILT_W`, default 8: glitch-filter width-counter width.

Ports:
- `clock`  in  1: single system clock.
- `FPGA_rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle arm pulse.
- `ch_en`  in  NUM_CH: channels included in the run; sampled at `start`.
- `target_blinks`  in  CNT_W: blinks required per channel; sampled at `start`.
- `timeout_cycles`  in  TMO_W: run limit; 0 means no limit; sampled at `start`.
- `min_width`  in  FILT_W: minimum stable cycles for a level change; 0 is treated as 1.
- `gpio_in`  in  NUM_CH: asynchronous monitored lines.
- `blink_count`  out  NUM_CH*CNT_W: per-channel counts, channel i at `[i*CNT_W +: CNT_W]`.
- `ch_pass`  out  NUM_CH: sticky per-channel pass.
- `ch_fail`  out  NUM_CH: sticky per-channel fail.
- `busy`  out  1: run in progress.
- `done`  out  1: one-cycle completion pulse.
- `all_pass`  out  1: valid from `done` until the next `start`.

## Operation
- Reset values: all outputs 0, global FSM in IDLE.
- Global FSM:
  - IDLE → RUN on `start`.
  - RUN → DONE when every enabled channel has resolved (pass or fail).
  - DONE → IDLE unconditionally after one cycle. `done` = 1 in DONE.
- `start` in any state, including RUN, restarts the run. It clears counts, pass, fail, `all_pass` and the timeout counter, and re-samples the configuration inputs.
- Per channel:
  - `SYNC_STAGES` flops feed the glitch filter.
  - The filter output changes only after the synced input has held the new level for `max(min_width,1)` consecutive cycles. A shorter excursion resets the width counter and is discarded.
  - On `start`, the filter output is loaded with the current synced level, so a line already high does not produce a rise.
- Blink: a filtered rise followed by a filtered fall, counted on the fall. A fall without a preceding rise since `start` is not counted.
- Counts saturate at 2^CNT_W−1. Blinks after pass are still counted; pass is held.
- Pass: set when count == `target_blinks`. With `target_blinks` = 0, pass is set on the first RUN cycle.
- Fail: when the timeout counter reaches `timeout_cycles` (nonzero), every enabled, unresolved channel sets fail in that cycle.
- Disabled channels:
  - Never pass or fail.
  - Count stays at 0.
  - Count as resolved.
- `all_pass` = AND of pass over enabled channels, latched in DONE. With `ch_en` = 0, the run ends after one RUN cycle and `all_pass` = 0.

## Timing
- `start` at cycle t: `busy` = 1 and counters = 0 at t+1.
- Input fall sampled at cycle t: count increments at t + SYNC_STAGES + max(min_width,1) + 1.
- Pass is visible the cycle after the count reaches target.
- Timeout counter starts at 0 at t+1. Fail is visible at t+1+`timeout_cycles`.
- If pass and timeout resolve in the same cycle, pass wins.
- `done` is 1 cycle after the last resolution. `busy` falls in the same cycle `done` rises.
- `FPGA_rst` mid-run aborts with no `done` and returns all outputs to reset values at the next edge.

## Structure
- Package/header `gpio_chk_pkg`:
  - FSM state encoding (IDLE/RUN/DONE).
  - Per-channel phase encoding (WAIT_RISE/WAIT_FALL).
  - Count-saturate helper.
- Sub-module `gpio_pulse_ch`: synchroniser, glitch filter, blink counter and pass/fail for one channel. Instantiated `NUM_CH` times via generate.
- The top holds the global FSM, timeout counter and reduction logic.

## Test plan
- NUM_CH=1, target=10, min_width=4, 10 clean 200-cycle blinks, timeout 0 → `blink_count`=10, `ch_pass`=1, `done` pulse, `all_pass`=1.
- 3-cycle high glitches interleaved with 3 valid blinks, min_width=4, target=3 → count exactly 3, pass.
- NUM_CH=4, `ch_en`=4'b1011, channel 1 stuck low, timeout=5000 → channels 0 and 3 pass, channel 1 fail at start+5001, channel 2 count 0, `all_pass`=0.
- Line high at `start`, then falls, then 2 blinks with target=2 → count 2, not 3.
- `start` re-issued mid-run after 4 blinks → counts return to 0 at t+1, `done` from the first run never pulses.
- `FPGA_rst` during RUN, and CNT_W=2 with 5 blinks → reset returns all outputs to 0; count saturates at 3.

Source files
------------

// File: rtl/gpio_chk_pkg.sv
// Shared encodings and helpers for the GPIO blink checker.
// Covers the global run FSM, the per-channel blink phase and the saturating count step.
package gpio_chk_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [0:0] PH_WAIT_RISE = 1'b0;
    localparam logic [0:0] PH_WAIT_FALL = 1'b1;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/gpio_pulse_ch.sv
// One monitored line: synchroniser, glitch filter, blink counter and sticky pass/fail.
// Counting and resolution happen only while the global run is active and the channel is enabled.
module gpio_pulse_ch
    import gpio_chk_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic              clock,
    input  logic              FPGA_rst,
    input  logic              start,
    input  logic              run,
    input  logic              en,
    input  logic [CNT_W-1:0]  target,
    input  logic              timeout_hit,
    input  logic [FILT_W-1:0] min_width,
    input  logic              gpio,
    output logic [CNT_W-1:0]  count,
    output logic              pass,
    output logic              fail
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_W-1:0]      width_cnt;
    logic [FILT_W-1:0]      width_eff;
    logic                   synced;
    logic                   filt;
    logic                   phase;
    logic                   flip;
    logic                   rise;
    logic                   fall;
    logic                   active;
    logic                   at_target;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign width_eff = (min_width == '0) ? FILT_W'(1) : min_width;
    // The filter flips only once the differing level has outlasted the width counter.
    assign flip      = (synced != filt) && (width_cnt >= width_eff);
    assign rise      = flip && synced;
    assign fall      = flip && !synced;
    assign active    = run && en;
    assign at_target = (count == target);

    always_ff @(posedge clock) begin
        if (FPGA_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio};
        end
    end

    always_ff @(posedge clock) begin
        if (FPGA_rst) begin
            filt      <= 1'b0;
            width_cnt <= '0;
            phase     <= PH_WAIT_RISE;
            count     <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
        end else if (start) begin
            // Adopt the current level so a line already high is not seen as a rise.
            filt      <= synced;
            width_cnt <= '0;
            phase     <= PH_WAIT_RISE;
            count     <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            if (synced == filt) begin
                width_cnt <= '0;
            end else if (flip) begin
                filt      <= synced;
                width_cnt <= '0;
            end else begin
                width_cnt <= width_cnt + FILT_W'(1);
            end

            if (rise) begin
                phase <= PH_WAIT_FALL;
            end else if (fall) begin
                phase <= PH_WAIT_RISE;
            end

            if (active && fall && (phase == PH_WAIT_FALL)) begin
                count <= CNT_W'(sat_inc(32'(count), CNT_MAX));
            end

            // Reaching the target in the timeout cycle still counts as a pass.
            if (active && !fail && at_target) begin
                pass <= 1'b1;
            end
            if (active && !pass && !at_target && timeout_hit) begin
                fail <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_pulse_checker.sv
// Multi-line blink self-test monitor: global run FSM, timeout counter and pass reduction.
// start is a single-cycle pulse with no handshake; it restarts a run from any state.
module gpio_pulse_checker
    import gpio_chk_pkg::*;
#(
    parameter int NUM_CH      = 1,
    parameter int CNT_W       = 8,
    parameter int TMO_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic                    clock,
    input  logic                    FPGA_rst,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [CNT_W-1:0]        target_blinks,
    input  logic [TMO_W-1:0]        timeout_cycles,
    input  logic [FILT_W-1:0]       min_width,
    input  logic [NUM_CH-1:0]       gpio_in,
    output logic [NUM_CH*CNT_W-1:0] blink_count,
    output logic [NUM_CH-1:0]       ch_pass,
    output logic [NUM_CH-1:0]       ch_fail,
    output logic                    busy,
    output logic                    done,
    output logic                    all_pass,
    output logic [1:0]              dbg_state
);

    logic [1:0]        state;
    logic [NUM_CH-1:0] en_q;
    logic [CNT_W-1:0]  target_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              run;
    logic              timeout_hit;
    logic              all_resolved;

    assign run          = (state == ST_RUN);
    assign busy         = run;
    assign done         = (state == ST_DONE);
    assign dbg_state    = state;
    assign timeout_hit  = run && (tmo_q != '0) && (tmo_cnt == tmo_q - TMO_W'(1));
    // Disabled channels are treated as already resolved.
    assign all_resolved = &(ch_pass | ch_fail | ~en_q);

    always_ff @(posedge clock) begin
        if (FPGA_rst) begin
            state    <= ST_IDLE;
            en_q     <= '0;
            target_q <= '0;
            tmo_q    <= '0;
            tmo_cnt  <= '0;
            all_pass <= 1'b0;
        end else if (start) begin
            state    <= ST_RUN;
            en_q     <= ch_en;
            target_q <= target_blinks;
            tmo_q    <= timeout_cycles;
            tmo_cnt  <= '0;
            all_pass <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_IDLE;
                ST_RUN: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (all_resolved) begin
                        state    <= ST_DONE;
                        all_pass <= (|en_q) && (&(ch_pass | ~en_q));
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        gpio_pulse_ch #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_W     (FILT_W)
        ) u_ch (
            .clock      (clock),
            .FPGA_rst   (FPGA_rst),
            .start      (start),
            .run        (run),
            .en         (en_q[i]),
            .target     (target_q),
            .timeout_hit(timeout_hit),
            .min_width  (min_width),
            .gpio       (gpio_in[i]),
            .count      (blink_count[i*CNT_W +: CNT_W]),
            .pass       (ch_pass[i]),
            .fail       (ch_fail[i])
        );
    end

endmodule

// File: tb/tb_gpio_pulse_checker.sv
// Directed and randomized runs of gpio_pulse_checker against a timeline model of blinks.
// Each blink's count-visible cycle is recorded as the waveform is generated; outputs follow from those times.
module tb_gpio_pulse_checker;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 4;
    localparam int TMO_W   = 16;
    localparam int SYNC    = 2;
    localparam int FILT_W  = 4;
    localparam int CNT_MAX = 15;
    localparam int INF     = 1 << 30;

    logic                    clock = 1'b0;
    logic                    FPGA_rst;
    logic                    start;
    logic [NUM_CH-1:0]       ch_en;
    logic [CNT_W-1:0]        target_blinks;
    logic [TMO_W-1:0]        timeout_cycles;
    logic [FILT_W-1:0]       min_width;
    logic [NUM_CH-1:0]       gpio_in;
    logic [NUM_CH*CNT_W-1:0] blink_count;
    logic [NUM_CH-1:0]       ch_pass;
    logic [NUM_CH-1:0]       ch_fail;
    logic                    busy;
    logic                    done;
    logic                    all_pass;
    logic [1:0]              dbg_state;

    int errors = 0;
    int checks = 0;
    int cur_r  = 0;
    int weff   = 4;

    bit wave_q[NUM_CH][$];
    int times_q[NUM_CH][$];

    gpio_pulse_checker #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TMO_W(TMO_W), .SYNC_STAGES(SYNC), .FILT_W(FILT_W)
    ) dut (
        .clock(clock), .FPGA_rst(FPGA_rst), .start(start), .ch_en(ch_en),
        .target_blinks(target_blinks), .timeout_cycles(timeout_cycles), .min_width(min_width),
        .gpio_in(gpio_in), .blink_count(blink_count), .ch_pass(ch_pass), .ch_fail(ch_fail),
        .busy(busy), .done(done), .all_pass(all_pass), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s r=%0d observed=%0h expected=%0h", tag, cur_r, obs, exp);
        end
    endtask

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    task automatic clear_model();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wave_q[ch].delete();
            times_q[ch].delete();
        end
    endtask

    task automatic add_seg(input int ch, input bit lvl, input int len);
        for (int k = 0; k < len; k++) wave_q[ch].push_back(lvl);
    endtask

    // Valid segments are at least weff+3 long, glitches at most weff-1, so the filter outcome is unambiguous.
    task automatic gen_ch(input int ch, input bit init_high, input int nblinks, input bit glitchy,
                          input int seg_lo, input int seg_hi);
        if (init_high) add_seg(ch, 1'b1, rnd(seg_lo, seg_hi));
        for (int b = 0; b < nblinks; b++) begin
            add_seg(ch, 1'b0, rnd(seg_lo, seg_hi));
            if (glitchy && weff > 1) begin
                add_seg(ch, 1'b1, rnd(1, weff - 1));
                add_seg(ch, 1'b0, rnd(2, 6));
            end
            add_seg(ch, 1'b1, rnd(seg_lo, seg_hi));
            if (glitchy && weff > 1) begin
                add_seg(ch, 1'b0, rnd(1, weff - 1));
                add_seg(ch, 1'b1, rnd(seg_lo, seg_hi));
            end
            times_q[ch].push_back(wave_q[ch].size() + SYNC + weff + 1);
        end
        add_seg(ch, 1'b0, weff + SYNC + 8);
    endtask

    task automatic drive_wave(input int j);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (wave_q[ch].size() == 0) gpio_in[ch] = 1'b0;
            else if (j < wave_q[ch].size()) gpio_in[ch] = wave_q[ch][j];
            else gpio_in[ch] = wave_q[ch][wave_q[ch].size() - 1];
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "/busy"}, 64'(busy), 64'd0);
        chk({name, "/done"}, 64'(done), 64'd0);
        chk({name, "/all_pass"}, 64'(all_pass), 64'd0);
        chk({name, "/ch_pass"}, 64'(ch_pass), 64'd0);
        chk({name, "/ch_fail"}, 64'(ch_fail), 64'd0);
        chk({name, "/blink_count"}, 64'(blink_count), 64'd0);
    endtask

    task automatic do_run(input string name, input logic [NUM_CH-1:0] en, input int tgt, input int tmo,
                          input int mw, input int preroll, input int abort_at);
        int p[NUM_CH];
        int f[NUM_CH];
        int last, dn, limit, c;
        bit ap;
        logic [NUM_CH-1:0]       pass_e, fail_e;
        logic [NUM_CH*CNT_W-1:0] cnt_e;

        min_width = FILT_W'(mw);
        for (int k = 0; k < preroll; k++) begin
            drive_wave(0);
            @(posedge clock); #1;
        end

        last = 1;
        ap   = (en != '0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            p[ch] = INF;
            f[ch] = INF;
            if (en[ch]) begin
                if (tgt == 0) p[ch] = 2;
                else if (tgt <= times_q[ch].size()) p[ch] = times_q[ch][tgt - 1] + 1;
                if (tmo > 0 && p[ch] > tmo + 1) begin
                    p[ch] = INF;
                    f[ch] = tmo + 1;
                end
                if (p[ch] == INF) ap = 1'b0;
                if ((p[ch] < f[ch] ? p[ch] : f[ch]) > last) last = (p[ch] < f[ch]) ? p[ch] : f[ch];
            end
        end
        dn    = (last >= INF) ? INF : last + 1;
        limit = (abort_at > 0) ? abort_at : ((dn >= INF) ? 20000 : dn + 3);

        ch_en          = en;
        target_blinks  = CNT_W'(tgt);
        timeout_cycles = TMO_W'(tmo);
        start          = 1'b1;
        drive_wave(0);
        for (int r = 1; r <= limit; r++) begin
            @(posedge clock); #1;
            start = 1'b0;
            cur_r = r;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                c = 0;
                if (en[ch]) begin
                    for (int k = 0; k < times_q[ch].size(); k++)
                        if (times_q[ch][k] <= r && times_q[ch][k] <= dn) c++;
                end
                if (c > CNT_MAX) c = CNT_MAX;
                cnt_e[ch*CNT_W +: CNT_W] = CNT_W'(c);
                pass_e[ch] = (r >= p[ch]);
                fail_e[ch] = (r >= f[ch]);
            end
            chk({name, "/busy"}, 64'(busy), 64'(r < dn));
            chk({name, "/done"}, 64'(done), 64'(r == dn));
            chk({name, "/all_pass"}, 64'(all_pass), 64'((r >= dn) ? ap : 1'b0));
            chk({name, "/ch_pass"}, 64'(ch_pass), 64'(pass_e));
            chk({name, "/ch_fail"}, 64'(ch_fail), 64'(fail_e));
            chk({name, "/blink_count"}, 64'(blink_count), 64'(cnt_e));
            drive_wave(r);
        end
    endtask

    initial begin
        int abort_at;
        int nb;
        int tgt;
        int tmo;
        logic [NUM_CH-1:0] en;

        FPGA_rst = 1'b1; start = 1'b0; ch_en = '0; target_blinks = '0;
        timeout_cycles = '0; min_width = FILT_W'(4); gpio_in = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset");
        FPGA_rst = 1'b0;

        // Ten clean 200-cycle blinks on a single channel.
        weff = 4; clear_model();
        gen_ch(0, 1'b0, 10, 1'b0, 100, 100);
        do_run("clean10", 4'b0001, 10, 0, 4, 20, 0);

        // Short high glitches between valid blinks must not count.
        weff = 4; clear_model();
        gen_ch(0, 1'b0, 3, 1'b1, weff + 3, weff + 10);
        do_run("glitch3", 4'b0001, 3, 0, 4, 20, 0);

        // Stuck channel times out, disabled channel stays at zero.
        weff = 4; clear_model();
        gen_ch(0, 1'b0, 5, 1'b1, weff + 3, weff + 12);
        gen_ch(1, 1'b0, 0, 1'b0, weff + 3, weff + 12);
        gen_ch(2, 1'b0, 4, 1'b0, weff + 3, weff + 12);
        gen_ch(3, 1'b0, 5, 1'b0, weff + 3, weff + 12);
        do_run("stuck", 4'b1011, 5, 5000, 4, 20, 0);

        // Line high at start: its first fall is not a blink.
        weff = 4; clear_model();
        gen_ch(0, 1'b1, 2, 1'b0, weff + 3, weff + 12);
        do_run("high_at_start", 4'b0001, 2, 0, 4, 20, 0);

        // Restart mid-run after four blinks.
        weff = 4; clear_model();
        gen_ch(0, 1'b0, 4, 1'b0, weff + 3, weff + 12);
        abort_at = wave_q[0].size() + 2;
        do_run("pre_restart", 4'b0001, 9, 0, 4, 20, abort_at);
        clear_model();
        gen_ch(0, 1'b0, 3, 1'b0, weff + 3, weff + 12);
        do_run("restart", 4'b0001, 3, 0, 4, 0, 0);

        // Reset in the middle of a run.
        weff = 4; clear_model();
        gen_ch(0, 1'b0, 6, 1'b0, weff + 3, weff + 12);
        gen_ch(1, 1'b0, 6, 1'b0, weff + 3, weff + 12);
        do_run("pre_reset", 4'b0011, 12, 0, 4, 20, 60);
        FPGA_rst = 1'b1;
        @(posedge clock); #1;
        cur_r = 0;
        chk_zero("mid_reset");
        FPGA_rst = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_zero("after_reset");

        // Count saturates while a stuck channel keeps the run alive.
        weff = 2; clear_model();
        gen_ch(0, 1'b0, 18, 1'b1, weff + 3, weff + 8);
        gen_ch(1, 1'b0, 0, 1'b0, weff + 3, weff + 8);
        do_run("saturate", 4'b0011, 15, wave_q[0].size() + 40, 2, 20, 0);

        // min_width of zero behaves as one.
        weff = 1; clear_model();
        for (int ch = 0; ch < NUM_CH; ch++) gen_ch(ch, 1'b0, 3, 1'b0, weff + 3, weff + 9);
        do_run("mw_zero", 4'b1111, 3, 0, 0, 20, 0);

        // No channels enabled, and target zero racing a one-cycle timeout.
        weff = 4; clear_model();
        do_run("no_ch", 4'b0000, 3, 0, 4, 20, 0);
        do_run("tgt_zero", 4'b0101, 0, 1, 4, 20, 0);

        for (int it = 0; it < 6; it++) begin
            weff = rnd(1, 5);
            clear_model();
            en  = NUM_CH'(rnd(0, 15));
            tgt = rnd(0, 5);
            tmo = (rnd(0, 1) == 1) ? rnd(40, 500) : 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                nb = (tmo == 0) ? tgt + rnd(0, 2) : rnd(0, 6);
                gen_ch(ch, rnd(0, 1) == 1, nb, 1'b1, weff + 3, weff + 12);
            end
            do_run($sformatf("rand%0d", it), en, tgt, tmo, weff, 20, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
